// File: rtl/muxn_selftest_if.sv
// Harness-to-environment bundle for muxn_selftest: DUV stimulus, DUV response
// and the run control/result signals.
interface muxn_selftest_if #(
    parameter int SEL_W = 2,
    parameter int ERR_W = 8
);
    localparam int N = 1 << SEL_W;

    logic                 Start;
    logic [N-1:0]         In;
    logic [SEL_W-1:0]     Sel;
    logic                 DutOut;
    logic                 Busy;
    logic                 Done;
    logic                 Pass;
    logic [ERR_W-1:0]     ErrCount;
    logic                 FirstFailValid;
    logic [SEL_W+N-1:0]   FirstFailVec;

    modport master (
        input  Start, DutOut,
        output In, Sel, Busy, Done, Pass, ErrCount, FirstFailValid, FirstFailVec
    );

    modport slave (
        output Start, DutOut,
        input  In, Sel, Busy, Done, Pass, ErrCount, FirstFailValid, FirstFailVec
    );
endinterface

// File: rtl/muxn_selftest.sv
// Exhaustive self-test harness for an N:1 single-bit mux: drives every {Sel, In}
// vector, checks DutOut against In[Sel] after LATENCY cycles and summarises.
module muxn_selftest #(
    parameter int SEL_W   = 2,
    parameter int LATENCY = 0,
    parameter int ERR_W   = 8
) (
    input logic             Clock,
    input logic             nReset,
    muxn_selftest_if.master bus
);

    localparam int N  = 1 << SEL_W;
    localparam int VW = SEL_W + N;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [VW-1:0] VEC_LAST   = '1;
    localparam logic [2:0]    DRAIN_LAST = 3'(LATENCY - 1);

    logic [1:0]       state;
    logic [VW-1:0]    vec;
    logic [2:0]       drain_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic             ff_vld;
    logic [VW-1:0]    ff_vec;

    logic             start_ok;
    logic             active;
    logic [N-1:0]     in_drv;
    logic [SEL_W-1:0] sel_drv;
    logic             exp_p0;
    logic             chk_vld;
    logic             chk_exp;
    logic [VW-1:0]    chk_vec;
    logic             mismatch;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    assign start_ok = bus.Start && ((state == S_IDLE) || (state == S_DONE));
    assign active   = (state == S_RUN) || (state == S_DRAIN);
    assign in_drv   = active ? vec[N-1:0]  : '0;
    assign sel_drv  = active ? vec[VW-1:N] : '0;
    assign exp_p0   = in_drv[sel_drv];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= S_IDLE;
            vec       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (vec == VEC_LAST) begin
                        drain_cnt <= '0;
                        state     <= (LATENCY > 0) ? S_DRAIN : S_DONE;
                    end else begin
                        vec <= vec + VW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= S_DONE;
                    else drain_cnt <= drain_cnt + 3'd1;
                end
                default: begin
                    if (start_ok) begin
                        state <= S_RUN;
                        vec   <= '0;
                    end
                end
            endcase
        end
    end

    // Delay line: expected bit and vector index follow the DUV pipeline
    generate
        if (LATENCY == 0) begin : g_comb
            assign chk_vld = (state == S_RUN);
            assign chk_exp = exp_p0;
            assign chk_vec = vec;
        end else begin : g_dly
            logic [LATENCY-1:0] vld_p1;
            logic [LATENCY-1:0] exp_p1;
            logic [VW-1:0]      vec_p1 [LATENCY];

            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) begin
                    vld_p1 <= '0;
                    exp_p1 <= '0;
                    for (int i = 0; i < LATENCY; i++) vec_p1[i] <= '0;
                end else begin
                    vld_p1[0] <= (state == S_RUN);
                    exp_p1[0] <= exp_p0;
                    vec_p1[0] <= vec;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_p1[i] <= vld_p1[i-1];
                        exp_p1[i] <= exp_p1[i-1];
                        vec_p1[i] <= vec_p1[i-1];
                    end
                end
            end

            assign chk_vld = vld_p1[LATENCY-1];
            assign chk_exp = exp_p1[LATENCY-1];
            assign chk_vec = vec_p1[LATENCY-1];
        end
    endgenerate

    // Case inequality so an X/Z response is scored as a failure
    assign mismatch = chk_vld && (bus.DutOut !== chk_exp);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            err_cnt <= '0;
            ff_vld  <= 1'b0;
            ff_vec  <= '0;
        end else if (start_ok) begin
            err_cnt <= '0;
            ff_vld  <= 1'b0;
            ff_vec  <= '0;
        end else if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (!ff_vld) begin
                ff_vld <= 1'b1;
                ff_vec <= chk_vec;
            end
        end
    end

    assign bus.In             = in_drv;
    assign bus.Sel            = sel_drv;
    assign bus.Busy           = active;
    assign bus.Done           = (state == S_DONE);
    assign bus.Pass           = (state == S_DONE) && (err_cnt == '0);
    assign bus.ErrCount       = err_cnt;
    assign bus.FirstFailValid = ff_vld;
    assign bus.FirstFailVec   = ff_vec;

endmodule
